pe_vector_exec: RTL and testbench
=================================

Name: pe_vector_exec

Overview:
- Vector execution stage directly downstream of the PE fetch unit.
- Consumes pe_opcode, data_a and data_b each cycle.
- Elementwise ops (ADD/SUB/MUL) return a full vector on the stage-1 result path. DOTP runs a multi-cycle multiply and reduction tree and returns a scalar on the stage-2 path.
- Generates the store_result strobe the fetch unit uses to commit its result register.

Parameters:
- DATA_LEN, 32: lane width in bits.
- PE_ELEMENTS, 4: number of lanes; must be a power of 2 and at least 2.
- PE_OPCODE_LEN, 3: width of pe_opcode.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- pe_opcode, input, PE_OPCODE_LEN: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DOTP, 5 STORE_TEMP_S1, 6 STORE_TEMP_S2, 7 STORE_RESULT; sampled every cycle.
- data_a, input, DATA_LEN*PE_ELEMENTS: operand vector A; lane i = bits [DATA_LEN*i +: DATA_LEN].
- data_b, input, DATA_LEN*PE_ELEMENTS: operand vector B, same lane layout.
- pe_stage_1_valid, output, 1: one-cycle pulse, elementwise result valid.
- pe_stage_1_output, output, DATA_LEN*PE_ELEMENTS: elementwise result.
- pe_stage_2_valid, output, 1: one-cycle pulse, dot-product result valid.
- pe_stage_2_output, output, DATA_LEN: dot-product scalar.
- store_result, output, 1: one-cycle commit strobe.
- busy, output, 1: DOTP in flight; high in DP_MUL and DP_RED.
- issue_drop, output, 1: sticky; set when an op is discarded while busy.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, store_pending 0.
- Reset mid-DOTP: operation abandoned, no stage-2 pulse afterwards.
- Issue rule: every cycle with a non-zero pe_opcode is one issue.
- Arithmetic: unsigned, modulo 2^DATA_LEN per lane.
  - MUL keeps the low DATA_LEN bits of each product.
  - DOTP sum wraps modulo 2^DATA_LEN.
- ADD/SUB/MUL issued in IDLE at edge T:
  - pe_stage_1_output registered at edge T.
  - pe_stage_1_valid high for exactly the cycle after edge T (latency 1).
  - Output holds its value until the next elementwise op.
- DOTP FSM, R = $clog2(PE_ELEMENTS):
  - IDLE --DOTP--> DP_MUL: lane products registered; level counter cleared.
  - DP_MUL -> DP_RED: first pairwise tree level registered.
  - DP_RED: one tree level per cycle. After the last level, pe_stage_2_output is loaded, pe_stage_2_valid pulses one cycle, and the FSM returns to IDLE.
  - Latency from issue edge to valid cycle: 1+R (3 for PE_ELEMENTS=4).
  - DOTP never asserts pe_stage_1_valid.
- Ops issued while busy:
  - ADD/SUB/MUL/DOTP: dropped, issue_drop set (cleared only by rst).
  - Opcodes 5 and 6: NOP here, never dropped, never flagged.
- STORE_RESULT (7):
  - Issued in IDLE with no stage-1 pulse scheduled: store_result pulses the cycle after issue.
  - Issued the cycle right after an ADD/SUB/MUL, or while busy: store_pending set.
  - A pending store pulses store_result in the cycle after the last pe_stage_1_valid or pe_stage_2_valid pulse.
  - Multiple STOREs while pending merge into one pulse, not flagged.
- Simultaneous events:
  - A DOTP issued in the same cycle that pe_stage_2_valid pulses is accepted, because the FSM is already IDLE.
  - store_result never coincides with either valid pulse.

Optional Feature:
- Macro: PE_SAT_SIGNED_EN.
- Defined:
  - Operands are signed two's complement.
  - ADD/SUB/MUL lanes and every DOTP tree level saturate to [-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1].
  - Products use a 2*DATA_LEN intermediate before clamping.
- Undefined: unsigned wrap arithmetic as above; no saturation logic synthesised.

Test Plan:
- Reset, then ADD with A lanes {1,2,3,4}, B lanes {10,20,30,40} -> pe_stage_1_valid one cycle after issue, output lanes {11,22,33,44}; all outputs 0 during rst.
- SUB with A=0, B=1 in all lanes -> every lane 0xFFFFFFFF; MUL with 0x10000 x 0x10000 -> 0 (wrap).
- DOTP with A={1,2,3,4}, B={5,6,7,8} -> busy for 2 cycles, pe_stage_2_valid exactly 3 cycles after issue, value 70; no stage-1 pulse.
- DOTP followed by ADD the next cycle -> ADD dropped, issue_drop sticks at 1, stage-2 result still 70.
- STORE_RESULT issued one cycle after DOTP -> single store_result pulse in the cycle after pe_stage_2_valid; a second STORE while pending gives no extra pulse.
- rst asserted in DP_RED -> no pe_stage_2_valid afterwards, busy 0 the cycle after rst. With PE_SAT_SIGNED_EN, ADD 0x7FFFFFFF+1 -> 0x7FFFFFFF.

Source files
------------

// File: rtl/pe_vector_exec.sv
// rtl/pe_vector_exec.sv - PE vector execution stage: elementwise ALU plus multi-cycle dot product
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   pe_opcode           0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DOTP, 5/6 STORE_TEMP, 7 STORE_RESULT
//   data_a, data_b      operand vectors, lane i = [DATA_LEN*i +: DATA_LEN]
//   pe_stage_1_valid    one-cycle pulse, elementwise result valid
//   pe_stage_1_output   elementwise result vector (held until next elementwise op)
//   pe_stage_2_valid    one-cycle pulse, dot-product result valid
//   pe_stage_2_output   dot-product scalar
//   store_result        one-cycle commit strobe for the fetch unit
//   busy                DOTP in flight
//   issue_drop          sticky flag, an op was discarded while busy
//
// Optional macro PE_SAT_SIGNED_EN: signed saturating arithmetic instead of unsigned wrap.
module pe_vector_exec #(
  parameter int DATA_LEN      = 32,
  parameter int PE_ELEMENTS   = 4,
  parameter int PE_OPCODE_LEN = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PE_OPCODE_LEN-1:0]        pe_opcode,
  input  logic [DATA_LEN*PE_ELEMENTS-1:0] data_a,
  input  logic [DATA_LEN*PE_ELEMENTS-1:0] data_b,
  output logic                            pe_stage_1_valid,
  output logic [DATA_LEN*PE_ELEMENTS-1:0] pe_stage_1_output,
  output logic                            pe_stage_2_valid,
  output logic [DATA_LEN-1:0]             pe_stage_2_output,
  output logic                            store_result,
  output logic                            busy,
  output logic                            issue_drop
);

  localparam int R     = $clog2(PE_ELEMENTS);
  localparam int LVL_W = $clog2(R + 1);
  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(R - 1);

  localparam logic [PE_OPCODE_LEN-1:0] OP_ADD   = PE_OPCODE_LEN'(1);
  localparam logic [PE_OPCODE_LEN-1:0] OP_SUB   = PE_OPCODE_LEN'(2);
  localparam logic [PE_OPCODE_LEN-1:0] OP_MUL   = PE_OPCODE_LEN'(3);
  localparam logic [PE_OPCODE_LEN-1:0] OP_DOTP  = PE_OPCODE_LEN'(4);
  localparam logic [PE_OPCODE_LEN-1:0] OP_STORE = PE_OPCODE_LEN'(7);

  typedef logic [DATA_LEN-1:0] lane_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DP_MUL, ST_DP_RED} state_t;

`ifdef PE_SAT_SIGNED_EN
  localparam int WW = 2 * DATA_LEN;
  localparam logic signed [WW-1:0] SAT_MAX_W = {{(DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN_W = {{(DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

  function automatic logic signed [WW-1:0] sext(input lane_t v);
    return $signed({{DATA_LEN{v[DATA_LEN-1]}}, v});
  endfunction

  // Double-width intermediate cannot overflow for a sum, difference or product of two lanes.
  function automatic lane_t clamp(input logic signed [WW-1:0] v);
    if (v > SAT_MAX_W) return {1'b0, {(DATA_LEN-1){1'b1}}};
    else if (v < SAT_MIN_W) return {1'b1, {(DATA_LEN-1){1'b0}}};
    else return v[DATA_LEN-1:0];
  endfunction

  function automatic lane_t lane_add(input lane_t a, input lane_t b);
    return clamp(sext(a) + sext(b));
  endfunction
  function automatic lane_t lane_sub(input lane_t a, input lane_t b);
    return clamp(sext(a) - sext(b));
  endfunction
  function automatic lane_t lane_mul(input lane_t a, input lane_t b);
    return clamp(sext(a) * sext(b));
  endfunction
`else
  function automatic lane_t lane_add(input lane_t a, input lane_t b);
    return a + b;
  endfunction
  function automatic lane_t lane_sub(input lane_t a, input lane_t b);
    return a - b;
  endfunction
  function automatic lane_t lane_mul(input lane_t a, input lane_t b);
    return a * b;
  endfunction
`endif

  state_t                          state_q, state_d;
  logic [LVL_W-1:0]                lvl_q, lvl_d;
  lane_t                           red_q [PE_ELEMENTS];
  lane_t                           red_d [PE_ELEMENTS];
  logic                            s1_valid_q, s1_valid_d;
  logic [DATA_LEN*PE_ELEMENTS-1:0] s1_out_q, s1_out_d;
  logic                            s2_valid_q, s2_valid_d;
  lane_t                           s2_out_q, s2_out_d;
  logic                            store_result_q, store_result_d;
  logic                            store_pending_q, store_pending_d;
  logic                            issue_drop_q, issue_drop_d;
  logic                            store_req;

  always_comb begin
    state_d         = state_q;
    lvl_d           = lvl_q;
    red_d           = red_q;
    s1_valid_d      = 1'b0;
    s1_out_d        = s1_out_q;
    s2_valid_d      = 1'b0;
    s2_out_d        = s2_out_q;
    store_result_d  = 1'b0;
    store_pending_d = store_pending_q;
    issue_drop_d    = issue_drop_q;
    store_req       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        case (pe_opcode)
          OP_ADD, OP_SUB, OP_MUL: begin
            for (int i = 0; i < PE_ELEMENTS; i++) begin
              if (pe_opcode == OP_ADD)
                s1_out_d[DATA_LEN*i +: DATA_LEN] = lane_add(data_a[DATA_LEN*i +: DATA_LEN],
                                                            data_b[DATA_LEN*i +: DATA_LEN]);
              else if (pe_opcode == OP_SUB)
                s1_out_d[DATA_LEN*i +: DATA_LEN] = lane_sub(data_a[DATA_LEN*i +: DATA_LEN],
                                                            data_b[DATA_LEN*i +: DATA_LEN]);
              else
                s1_out_d[DATA_LEN*i +: DATA_LEN] = lane_mul(data_a[DATA_LEN*i +: DATA_LEN],
                                                            data_b[DATA_LEN*i +: DATA_LEN]);
            end
            s1_valid_d = 1'b1;
          end
          OP_DOTP: begin
            for (int i = 0; i < PE_ELEMENTS; i++)
              red_d[i] = lane_mul(data_a[DATA_LEN*i +: DATA_LEN], data_b[DATA_LEN*i +: DATA_LEN]);
            lvl_d   = '0;
            state_d = ST_DP_MUL;
          end
          default: ;
        endcase
      end
      ST_DP_MUL, ST_DP_RED: begin
        if (pe_opcode == OP_ADD || pe_opcode == OP_SUB || pe_opcode == OP_MUL || pe_opcode == OP_DOTP)
          issue_drop_d = 1'b1;
        // One tree level per cycle, reduced in place: after level k the
        // first PE_ELEMENTS>>k entries hold the partial sums.
        for (int i = 0; i < PE_ELEMENTS / 2; i++)
          red_d[i] = lane_add(red_q[2*i], red_q[2*i+1]);
        lvl_d = lvl_q + 1'b1;
        if (lvl_q == LAST_LVL) begin
          s2_out_d   = lane_add(red_q[0], red_q[1]);
          s2_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DP_RED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A store fires only when no valid pulse is about to be produced and no
    // DOTP remains in flight, so it always lands after the last result pulse.
    store_req = (pe_opcode == OP_STORE) || store_pending_q;
    if (store_req) begin
      if (state_d == ST_IDLE && !s1_valid_d && !s2_valid_d) begin
        store_result_d  = 1'b1;
        store_pending_d = 1'b0;
      end else begin
        store_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      lvl_q           <= '0;
      for (int i = 0; i < PE_ELEMENTS; i++) red_q[i] <= '0;
      s1_valid_q      <= 1'b0;
      s1_out_q        <= '0;
      s2_valid_q      <= 1'b0;
      s2_out_q        <= '0;
      store_result_q  <= 1'b0;
      store_pending_q <= 1'b0;
      issue_drop_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      lvl_q           <= lvl_d;
      red_q           <= red_d;
      s1_valid_q      <= s1_valid_d;
      s1_out_q        <= s1_out_d;
      s2_valid_q      <= s2_valid_d;
      s2_out_q        <= s2_out_d;
      store_result_q  <= store_result_d;
      store_pending_q <= store_pending_d;
      issue_drop_q    <= issue_drop_d;
    end
  end

  assign pe_stage_1_valid  = s1_valid_q;
  assign pe_stage_1_output = s1_out_q;
  assign pe_stage_2_valid  = s2_valid_q;
  assign pe_stage_2_output = s2_out_q;
  assign store_result      = store_result_q;
  assign busy              = (state_q != ST_IDLE);
  assign issue_drop        = issue_drop_q;

endmodule

// File: tb/tb_pe_vector_exec.sv
// tb/tb_pe_vector_exec.sv - directed self-checking bench for pe_vector_exec
module tb_pe_vector_exec;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   pe_opcode;
  logic [127:0] data_a;
  logic [127:0] data_b;
  logic         pe_stage_1_valid;
  logic [127:0] pe_stage_1_output;
  logic         pe_stage_2_valid;
  logic [31:0]  pe_stage_2_output;
  logic         store_result;
  logic         busy;
  logic         issue_drop;

  int checks = 0;
  int errors = 0;

  pe_vector_exec #(.DATA_LEN(32), .PE_ELEMENTS(4), .PE_OPCODE_LEN(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .pe_opcode         (pe_opcode),
    .data_a            (data_a),
    .data_b            (data_b),
    .pe_stage_1_valid  (pe_stage_1_valid),
    .pe_stage_1_output (pe_stage_1_output),
    .pe_stage_2_valid  (pe_stage_2_valid),
    .pe_stage_2_output (pe_stage_2_output),
    .store_result      (store_result),
    .busy              (busy),
    .issue_drop        (issue_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] vec(input logic [31:0] l3, input logic [31:0] l2,
                                       input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pe_opcode = 3'd0; data_a = '0; data_b = '0;
    tick(); tick();
    chk("rst_s1_valid", 128'(pe_stage_1_valid), 128'd0);
    chk("rst_s1_out", pe_stage_1_output, 128'd0);
    chk("rst_s2_valid", 128'(pe_stage_2_valid), 128'd0);
    chk("rst_s2_out", 128'(pe_stage_2_output), 128'd0);
    chk("rst_store", 128'(store_result), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_drop", 128'(issue_drop), 128'd0);
    rst = 1'b0;

    // ADD
    pe_opcode = 3'd1; data_a = vec(4, 3, 2, 1); data_b = vec(40, 30, 20, 10);
    tick();
    chk("add_valid", 128'(pe_stage_1_valid), 128'd1);
    chk("add_out", pe_stage_1_output, vec(44, 33, 22, 11));
    chk("add_no_s2", 128'(pe_stage_2_valid), 128'd0);
    pe_opcode = 3'd0;
    tick();
    chk("add_valid_drop", 128'(pe_stage_1_valid), 128'd0);
    chk("add_out_hold", pe_stage_1_output, vec(44, 33, 22, 11));

    // SUB underflow wraps
    pe_opcode = 3'd2; data_a = '0; data_b = vec(1, 1, 1, 1);
    tick();
    chk("sub_out", pe_stage_1_output, {128{1'b1}});
    chk("sub_valid", 128'(pe_stage_1_valid), 128'd1);

    // MUL overflow (back-to-back with SUB)
    pe_opcode = 3'd3; data_a = vec(32'h10000, 32'h10000, 32'h10000, 32'h10000); data_b = data_a;
    tick();
`ifdef PE_SAT_SIGNED_EN
    chk("mul_out", pe_stage_1_output, vec(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF));
`else
    chk("mul_out", pe_stage_1_output, 128'd0);
`endif
    chk("mul_valid", 128'(pe_stage_1_valid), 128'd1);

    // ADD at the signed boundary
    pe_opcode = 3'd1; data_a = vec(0, 0, 0, 32'h7FFFFFFF); data_b = vec(0, 0, 0, 1);
    tick();
`ifdef PE_SAT_SIGNED_EN
    chk("add_boundary", pe_stage_1_output, vec(0, 0, 0, 32'h7FFFFFFF));
`else
    chk("add_boundary", pe_stage_1_output, vec(0, 0, 0, 32'h80000000));
`endif
    pe_opcode = 3'd0;
    tick();

    // STORE in idle with nothing scheduled
    pe_opcode = 3'd7;
    tick();
    chk("store_idle_pulse", 128'(store_result), 128'd1);
    pe_opcode = 3'd0;
    tick();
    chk("store_idle_end", 128'(store_result), 128'd0);

    // STORE the cycle right after an ADD
    pe_opcode = 3'd1; data_a = vec(1, 1, 1, 1); data_b = vec(2, 2, 2, 2);
    tick();
    chk("store_after_add_valid", 128'(pe_stage_1_valid), 128'd1);
    pe_opcode = 3'd7;
    tick();
    chk("store_after_add_novalid", 128'(pe_stage_1_valid), 128'd0);
    chk("store_after_add_pulse", 128'(store_result), 128'd1);
    pe_opcode = 3'd0;
    tick();
    chk("store_after_add_end", 128'(store_result), 128'd0);

    // DOTP: 5+12+21+32 = 70, latency 3
    pe_opcode = 3'd4; data_a = vec(4, 3, 2, 1); data_b = vec(8, 7, 6, 5);
    tick();
    chk("dotp_busy1", 128'(busy), 128'd1);
    chk("dotp_s2_early1", 128'(pe_stage_2_valid), 128'd0);
    chk("dotp_no_s1a", 128'(pe_stage_1_valid), 128'd0);
    pe_opcode = 3'd0;
    tick();
    chk("dotp_busy2", 128'(busy), 128'd1);
    chk("dotp_s2_early2", 128'(pe_stage_2_valid), 128'd0);
    tick();
    chk("dotp_s2_valid", 128'(pe_stage_2_valid), 128'd1);
    chk("dotp_s2_out", 128'(pe_stage_2_output), 128'd70);
    chk("dotp_idle", 128'(busy), 128'd0);
    chk("dotp_no_s1b", 128'(pe_stage_1_valid), 128'd0);
    tick();
    chk("dotp_s2_end", 128'(pe_stage_2_valid), 128'd0);
    chk("dotp_s2_hold", 128'(pe_stage_2_output), 128'd70);

    // DOTP then ADD while busy: ADD dropped
    pe_opcode = 3'd4; data_a = vec(4, 3, 2, 1); data_b = vec(8, 7, 6, 5);
    tick();
    pe_opcode = 3'd1; data_a = vec(9, 9, 9, 9); data_b = vec(9, 9, 9, 9);
    tick();
    chk("drop_flag", 128'(issue_drop), 128'd1);
    chk("drop_no_s1", 128'(pe_stage_1_valid), 128'd0);
    pe_opcode = 3'd0;
    tick();
    chk("drop_s2_valid", 128'(pe_stage_2_valid), 128'd1);
    chk("drop_s2_out", 128'(pe_stage_2_output), 128'd70);
    chk("drop_s1_unchanged", pe_stage_1_output, vec(3, 3, 3, 3));
    tick(); tick();
    chk("drop_sticky", 128'(issue_drop), 128'd1);

    // Clear flag, then STORE one cycle after DOTP plus a merged second STORE
    rst = 1'b1; tick(); rst = 1'b0;
    chk("drop_cleared", 128'(issue_drop), 128'd0);
    pe_opcode = 3'd4; data_a = vec(4, 3, 2, 1); data_b = vec(8, 7, 6, 5);
    tick();
    pe_opcode = 3'd7;
    tick();
    chk("pend_no_pulse1", 128'(store_result), 128'd0);
    tick();
    chk("pend_s2_valid", 128'(pe_stage_2_valid), 128'd1);
    chk("pend_no_pulse2", 128'(store_result), 128'd0);
    pe_opcode = 3'd6;
    tick();
    chk("pend_pulse", 128'(store_result), 128'd1);
    chk("pend_s2_end", 128'(pe_stage_2_valid), 128'd0);
    pe_opcode = 3'd0;
    tick();
    chk("pend_single", 128'(store_result), 128'd0);

    // DOTP accepted in the cycle stage-2 pulses; opcodes 5/6 while busy are harmless
    pe_opcode = 3'd4;
    tick();
    pe_opcode = 3'd0;
    tick(); tick();
    chk("b2b_first_valid", 128'(pe_stage_2_valid), 128'd1);
    pe_opcode = 3'd4; data_a = vec(2, 2, 2, 2); data_b = vec(3, 3, 3, 3);
    tick();
    chk("b2b_accepted_busy", 128'(busy), 128'd1);
    pe_opcode = 3'd5;
    tick();
    pe_opcode = 3'd6;
    tick();
    chk("b2b_second_valid", 128'(pe_stage_2_valid), 128'd1);
    chk("b2b_second_out", 128'(pe_stage_2_output), 128'd24);
    chk("b2b_no_drop", 128'(issue_drop), 128'd0);
    pe_opcode = 3'd0;
    tick();

    // Reset while in DP_RED abandons the operation
    pe_opcode = 3'd4; data_a = vec(4, 3, 2, 1); data_b = vec(8, 7, 6, 5);
    tick();
    pe_opcode = 3'd0;
    tick();
    chk("rstmid_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 128'(busy), 128'd0);
    chk("rstmid_s2_valid0", 128'(pe_stage_2_valid), 128'd0);
    tick();
    chk("rstmid_s2_valid1", 128'(pe_stage_2_valid), 128'd0);
    tick();
    chk("rstmid_s2_valid2", 128'(pe_stage_2_valid), 128'd0);
    chk("rstmid_s2_out", 128'(pe_stage_2_output), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
